cam_match_serializer: RTL and testbench
=======================================

# cam_match_serializer

Output stage of the exact-match CAM lookup path. Captures one NUM_COMP-bit match vector per lookup from the equality-checker stage and emits each matching entry index in ascending order, one per valid/ready beat. A lookup with no hits still produces exactly one miss beat, so every accepted vector yields at least one result beat. Feeds the row-selection/gather logic of the filter engine.

## Interface
- NUM_COMP, default 32: number of CAM entries, which is also the match-vector width; must be ≥2.
- IDX_WIDTH, default $clog2(NUM_COMP): index width; derived, not overridden.
- clk_i  in  1  single clock; all state updates on the rising edge.
- rst_ni  in  1  reset; synchronous, active-low.
- match_valid_i  in  1  match vector present on match_i.
- match_ready_o  out  1  stage can accept a vector this cycle.
- match_i  in  NUM_COMP  bit n = entry n matched (valid-qualified upstream).
- idx_valid_o  out  1  result beat present.
- idx_ready_i  in  1  consumer accepts result beat.
- idx_o  out  IDX_WIDTH  matching entry index; 0 on a miss beat.
- hit_o  out  1  1 = idx_o is a real hit; 0 = miss beat.
- idx_last_o  out  1  final beat of the current vector.
- count_o  out  IDX_WIDTH+1  popcount of the current vector; constant for all beats of that vector.

## Operation
- State: FSM {IDLE, DRAIN}; pending register (NUM_COMP bits); count register; miss flag.
- IDLE: match_ready_o=1, idx_valid_o=0. On match_valid_i&&match_ready_o: pending←match_i, count←popcount(match_i), miss←(match_i==0), go to DRAIN.
- DRAIN: idx_valid_o=1.
  - idx_o = index of the lowest set bit of pending.
  - hit_o = !miss.
  - idx_last_o = miss, or pending has exactly one bit set.
  - idx_o, hit_o, idx_last_o and count_o are driven only from registers through the encoder. They stay stable while idx_valid_o && !idx_ready_i.
- Beat handshake (idx_valid_o && idx_ready_i):
  - Not last: clear the lowest set bit of pending; stay in DRAIN.
  - Last: the vector is done. If match_valid_i is also high, load the new vector in the same cycle and stay in DRAIN. Otherwise go to IDLE.
- match_ready_o = (state==IDLE) || (idx_valid_o && idx_ready_i && idx_last_o). This is the only combinational input-to-output path (idx_ready_i → match_ready_o).
- Ordering: indices are emitted strictly ascending. No index is repeated or skipped. Exactly count_o hit beats are emitted, or 1 miss beat when count_o=0.
- count_o arithmetic: full IDX_WIDTH+1 bits so that all-ones (NUM_COMP hits) is representable; no saturation.
- match_i is sampled only on an accept handshake. Changes at any other time are ignored.

## Timing
- Reset (rst_ni=0 at a clock edge): state←IDLE, pending←0, count←0, miss←0.
  - Outputs during and after reset: idx_valid_o=0, idx_o=0, hit_o=0, idx_last_o=0, count_o=0.
  - match_ready_o=0 while rst_ni is low; it is 1 in the first cycle after release.
- Latency: a vector accepted at edge t produces its first beat valid in the cycle after t.
- Throughput: a vector with k hits occupies max(k,1) beat cycles. Back-to-back vectors with idx_ready_i held high give one beat per cycle with no bubble.
- Backpressure: idx_ready_i low holds all beat outputs and pending unchanged. match_ready_o stays 0 in DRAIN until the last beat handshakes.
- Reset mid-DRAIN: the in-flight vector is discarded with no further beats. idx_valid_o=0 in the cycle after the reset edge.
- Simultaneous last-beat handshake and new match_valid_i: the new vector is loaded, and the next cycle shows its first beat.
- Full vector (all NUM_COMP bits set): emits 0..NUM_COMP-1; last beat has idx_o=NUM_COMP-1 and count_o=NUM_COMP.

## Test plan
- Reset: hold rst_ni=0 for 2 cycles while driving match_valid_i=1 and match_i=32'hFFFF_FFFF.
  - During reset: all outputs 0, match_ready_o=0, no beat emitted.
  - After release: match_ready_o=1.
- Miss: accept 32'h0 with idx_ready_i=1 → exactly one beat with hit_o=0, idx_o=0, idx_last_o=1, count_o=0; then IDLE.
- Multi-hit: accept 32'h8000_0005 with idx_ready_i=1 → beats idx_o=0, 2, 31 on consecutive cycles, count_o=3 on every beat, idx_last_o=1 only on 31.
- Backpressure: for 32'h0000_0F00, drop idx_ready_i for 3 cycles at beat idx_o=9.
  - idx_o holds 9 and idx_valid_o holds 1 during the stall; match_ready_o=0.
  - Sequence completes 8, 9, 10, 11.
- Back-to-back: stream 32'h1, 32'h2, 32'h0 with match_valid_i and idx_ready_i held 1.
  - Beats are idx 0 (hit), idx 1 (hit), miss on 3 consecutive cycles.
  - match_ready_o is high on each last-beat cycle.
- Reset mid-operation: accept 32'hFFFF_FFFF, consume 4 beats, then assert rst_ni=0 for 1 cycle.
  - idx_valid_o=0 the next cycle.
  - A new vector 32'h10 then yields a single beat with idx_o=4, count_o=1, idx_last_o=1.

Source files
------------

// File: rtl/cam_match_serializer.sv
// Serializes a CAM match vector into ascending hit-index beats; an empty vector yields one miss beat.
// Latency: first beat is valid the cycle after the vector is accepted; one beat per cycle thereafter.
// Backpressure: idx_ready_i low freezes the beat; a new vector is taken only in IDLE or on the last beat.
module cam_match_serializer #(
   parameter int NUM_COMP  = 32,
   parameter int IDX_WIDTH = $clog2(NUM_COMP)
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 match_valid_i,
   output logic                 match_ready_o,
   input  logic [NUM_COMP-1:0]  match_i,
   output logic                 idx_valid_o,
   input  logic                 idx_ready_i,
   output logic [IDX_WIDTH-1:0] idx_o,
   output logic                 hit_o,
   output logic                 idx_last_o,
   output logic [IDX_WIDTH:0]   count_o
);

   typedef enum logic {
      IDLE  = 1'b0,
      DRAIN = 1'b1
   } state_t;

   localparam logic [NUM_COMP-1:0] PEND_ONE = {{(NUM_COMP-1){1'b0}}, 1'b1};

   state_t               state_q, state_d;
   logic [NUM_COMP-1:0]  pending_q, pending_d;
   logic [IDX_WIDTH:0]   count_q, count_d;
   logic                 miss_q, miss_d;

   logic [NUM_COMP-1:0]  pending_clr;
   logic [IDX_WIDTH-1:0] low_idx;
   logic [IDX_WIDTH:0]   match_cnt;
   logic                 single_bit;
   logic                 beat_last;
   logic                 beat_fire;
   logic                 draining;
   logic                 accept;

   // Clearing the lowest set bit also tells us whether exactly one bit remains.
   assign pending_clr = pending_q & (pending_q - PEND_ONE);
   assign single_bit  = (pending_q != '0) && (pending_clr == '0);

   always_comb begin
      low_idx = '0;
      for (int i = NUM_COMP - 1; i >= 0; i--) begin
         if (pending_q[i]) begin
            low_idx = IDX_WIDTH'(i);
         end
      end
   end

   always_comb begin
      match_cnt = '0;
      for (int i = 0; i < NUM_COMP; i++) begin
         match_cnt = match_cnt + (IDX_WIDTH + 1)'(match_i[i]);
      end
   end

   assign draining  = (state_q == DRAIN);
   assign beat_last = miss_q || single_bit;
   assign beat_fire = draining && idx_ready_i;

   // Only combinational input-to-output path: idx_ready_i lets the next vector in on the last beat.
   assign match_ready_o = rst_ni && (!draining || (beat_fire && beat_last));
   assign accept        = match_valid_i && match_ready_o;

   assign idx_valid_o = draining;
   assign idx_o       = draining ? low_idx : '0;
   assign hit_o       = draining && !miss_q;
   assign idx_last_o  = draining && beat_last;
   assign count_o     = draining ? count_q : '0;

   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      count_d   = count_q;
      miss_d    = miss_q;

      case (state_q)
         IDLE: begin
            state_d = IDLE;
         end
         DRAIN: begin
            if (beat_fire) begin
               if (beat_last) begin
                  state_d   = IDLE;
                  pending_d = '0;
                  miss_d    = 1'b0;
               end else begin
                  pending_d = pending_clr;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // A load overrides the drain update: it only happens in IDLE or on the last beat.
      if (accept) begin
         state_d   = DRAIN;
         pending_d = match_i;
         count_d   = match_cnt;
         miss_d    = (match_i == '0);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         pending_q <= '0;
         count_q   <= '0;
         miss_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         count_q   <= count_d;
         miss_q    <= miss_d;
      end
   end

endmodule

// File: tb/tb_cam_match_serializer.sv
// Bench for cam_match_serializer: directed literal checks plus randomized traffic against a beat-queue model.
module tb_cam_match_serializer;

   localparam int N  = 32;
   localparam int IW = $clog2(N);

   logic          clk;
   logic          rst_ni;
   logic          match_valid_i;
   logic          match_ready_o;
   logic [N-1:0]  match_i;
   logic          idx_valid_o;
   logic          idx_ready_i;
   logic [IW-1:0] idx_o;
   logic          hit_o;
   logic          idx_last_o;
   logic [IW:0]   count_o;

   int vectors;
   int errors;

   typedef struct {
      int idx;
      bit hit;
      bit last;
      int cnt;
   } beat_t;

   beat_t q[$];

   cam_match_serializer #(.NUM_COMP(N)) dut (
      .clk_i         (clk),
      .rst_ni        (rst_ni),
      .match_valid_i (match_valid_i),
      .match_ready_o (match_ready_o),
      .match_i       (match_i),
      .idx_valid_o   (idx_valid_o),
      .idx_ready_i   (idx_ready_i),
      .idx_o         (idx_o),
      .hit_o         (hit_o),
      .idx_last_o    (idx_last_o),
      .count_o       (count_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endfunction

   // Expected beats for one vector: every set bit in ascending order, or a single miss beat.
   function automatic void push_vector(logic [N-1:0] v);
      int cnt;
      int hi;
      beat_t b;
      cnt = 0;
      hi  = -1;
      for (int i = 0; i < N; i++) begin
         if (v[i]) begin
            cnt++;
            hi = i;
         end
      end
      if (cnt == 0) begin
         b.idx = 0; b.hit = 1'b0; b.last = 1'b1; b.cnt = 0;
         q.push_back(b);
      end else begin
         for (int i = 0; i < N; i++) begin
            if (v[i]) begin
               b.idx = i; b.hit = 1'b1; b.last = (i == hi); b.cnt = cnt;
               q.push_back(b);
            end
         end
      end
   endfunction

   // Compare process: checks handshake signals and beat contents every cycle against the model.
   always @(negedge clk) begin
      bit exp_rdy;
      bit busy;
      if (!rst_ni) begin
         chk("ready_in_reset", {63'd0, match_ready_o}, 64'd0);
         q.delete();
      end else begin
         busy    = (q.size() != 0);
         exp_rdy = !busy || (idx_ready_i && q[0].last);
         chk("match_ready", {63'd0, match_ready_o}, {63'd0, exp_rdy});
         chk("idx_valid", {63'd0, idx_valid_o}, {63'd0, busy});
         if (busy) begin
            if (idx_valid_o) begin
               chk("beat_idx", 64'(idx_o), 64'(q[0].idx));
               chk("beat_hit", {63'd0, hit_o}, {63'd0, q[0].hit});
               chk("beat_last", {63'd0, idx_last_o}, {63'd0, q[0].last});
               chk("beat_count", 64'(count_o), 64'(q[0].cnt));
            end
            if (idx_ready_i) begin
               void'(q.pop_front());
            end
         end
         if (match_valid_i && exp_rdy) begin
            push_vector(match_i);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic lit_beat(string name, int idx, bit hit, bit last, int cnt);
      @(negedge clk);
      chk({name, "_valid"}, {63'd0, idx_valid_o}, 64'd1);
      chk({name, "_idx"}, 64'(idx_o), 64'(idx));
      chk({name, "_hit"}, {63'd0, hit_o}, {63'd0, hit});
      chk({name, "_last"}, {63'd0, idx_last_o}, {63'd0, last});
      chk({name, "_count"}, 64'(count_o), 64'(cnt));
   endtask

   task automatic lit_idle(string name);
      @(negedge clk);
      chk({name, "_valid"}, {63'd0, idx_valid_o}, 64'd0);
   endtask

   initial begin
      logic [N-1:0] one;
      logic [N-1:0] v;
      int           sel;
      bit           drained;
      vectors = 0;
      errors  = 0;
      one     = 1;

      // Reset held for two edges with a full vector offered.
      rst_ni        = 1'b0;
      match_valid_i = 1'b1;
      match_i       = 32'hFFFF_FFFF;
      idx_ready_i   = 1'b1;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         chk("rst_ready", {63'd0, match_ready_o}, 64'd0);
         chk("rst_valid", {63'd0, idx_valid_o}, 64'd0);
         chk("rst_idx", 64'(idx_o), 64'd0);
         chk("rst_hit", {63'd0, hit_o}, 64'd0);
         chk("rst_last", {63'd0, idx_last_o}, 64'd0);
         chk("rst_count", 64'(count_o), 64'd0);
         if (c == 0) step();
      end
      step();
      rst_ni        = 1'b1;
      match_valid_i = 1'b0;
      @(negedge clk);
      chk("post_rst_ready", {63'd0, match_ready_o}, 64'd1);
      chk("post_rst_valid", {63'd0, idx_valid_o}, 64'd0);

      // Miss vector.
      step(); match_valid_i = 1'b1; match_i = 32'h0;
      step(); match_valid_i = 1'b0;
      lit_beat("miss", 0, 1'b0, 1'b1, 0);
      step(); lit_idle("miss_after");

      // Multi-hit vector.
      step(); match_valid_i = 1'b1; match_i = 32'h8000_0005;
      step(); match_valid_i = 1'b0;
      lit_beat("mh0", 0, 1'b1, 1'b0, 3);
      step(); lit_beat("mh2", 2, 1'b1, 1'b0, 3);
      step(); lit_beat("mh31", 31, 1'b1, 1'b1, 3);
      step(); lit_idle("mh_after");

      // Backpressure at beat 9.
      step(); match_valid_i = 1'b1; match_i = 32'h0000_0F00;
      step(); match_valid_i = 1'b0;
      lit_beat("bp8", 8, 1'b1, 1'b0, 4);
      for (int c = 0; c < 3; c++) begin
         step(); idx_ready_i = 1'b0;
         lit_beat("bp_stall", 9, 1'b1, 1'b0, 4);
         chk("bp_stall_ready", {63'd0, match_ready_o}, 64'd0);
      end
      step(); idx_ready_i = 1'b1;
      lit_beat("bp9", 9, 1'b1, 1'b0, 4);
      step(); lit_beat("bp10", 10, 1'b1, 1'b0, 4);
      step(); lit_beat("bp11", 11, 1'b1, 1'b1, 4);
      step(); lit_idle("bp_after");

      // Back-to-back vectors with no bubble.
      step(); match_valid_i = 1'b1; match_i = 32'h1;
      step(); match_i = 32'h2;
      lit_beat("b2b0", 0, 1'b1, 1'b1, 1);
      chk("b2b0_ready", {63'd0, match_ready_o}, 64'd1);
      step(); match_i = 32'h0;
      lit_beat("b2b1", 1, 1'b1, 1'b1, 1);
      chk("b2b1_ready", {63'd0, match_ready_o}, 64'd1);
      step(); match_valid_i = 1'b0;
      lit_beat("b2b_miss", 0, 1'b0, 1'b1, 0);
      chk("b2b_miss_ready", {63'd0, match_ready_o}, 64'd1);
      step(); lit_idle("b2b_after");

      // Full vector.
      step(); match_valid_i = 1'b1; match_i = 32'hFFFF_FFFF;
      step(); match_valid_i = 1'b0;
      for (int i = 0; i < N; i++) begin
         lit_beat("full", i, 1'b1, (i == N - 1), N);
         step();
      end
      lit_idle("full_after");

      // Reset in the middle of a drain.
      step(); match_valid_i = 1'b1; match_i = 32'hFFFF_FFFF;
      step(); match_valid_i = 1'b0;
      for (int c = 0; c < 3; c++) step();
      step(); rst_ni = 1'b0;
      step(); rst_ni = 1'b1; match_valid_i = 1'b1; match_i = 32'h10;
      lit_idle("midrst");
      step(); match_valid_i = 1'b0;
      lit_beat("midrst_new", 4, 1'b1, 1'b1, 1);
      step(); lit_idle("midrst_after");

      // Randomized traffic with occasional resets.
      for (int c = 0; c < 4000; c++) begin
         step();
         rst_ni        = ($urandom_range(0, 249) != 0);
         match_valid_i = ($urandom_range(0, 2) != 0);
         idx_ready_i   = ($urandom_range(0, 3) != 0);
         sel = $urandom_range(0, 7);
         case (sel)
            0: v = '0;
            1: v = '1;
            2: v = one << $urandom_range(0, N - 1);
            3: v = (one << $urandom_range(0, N - 1)) | (one << $urandom_range(0, N - 1));
            4: v = $urandom;
            default: v = $urandom & $urandom & $urandom;
         endcase
         match_i = v;
      end

      // Drain whatever is left, bounded.
      step();
      rst_ni        = 1'b1;
      match_valid_i = 1'b0;
      idx_ready_i   = 1'b1;
      drained       = 1'b0;
      for (int c = 0; c < 200 && !drained; c++) begin
         @(negedge clk);
         if (!idx_valid_o && q.size() == 0) drained = 1'b1;
         else step();
      end
      chk("final_drain", {63'd0, drained}, 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
